// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - start/data(LSB first)/parity/stop serial framer; optional PARITY_CHECK_EN input checker
module parity_serial_tx #(
    parameter int DATA_W     = 32,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              par_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int              BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]      CYC_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_W - 1);

    state_t            state, state_n;
    logic [7:0]        cyc, cyc_n;
    logic [BW-1:0]     bitc, bitc_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par, par_n;
    logic              tx_n;
    logic              accept;
    logic              cyc_last;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid & in_ready;
    assign cyc_last = (cyc == CYC_LAST);
    assign done     = (state == S_STOP) && cyc_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cyc   <= '0;
            bitc  <= '0;
            shreg <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            bitc  <= bitc_n;
            shreg <= shreg_n;
            par   <= par_n;
            tx    <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc_last ? '0 : cyc + 8'd1;
        bitc_n  = bitc;
        shreg_n = shreg;
        par_n   = par;
        case (state)
            S_IDLE: begin
                cyc_n  = '0;
                bitc_n = '0;
                if (accept) begin
                    state_n = S_START;
                    shreg_n = in_data;
                    par_n   = in_parity;
                end
            end
            S_START: begin
                if (cyc_last) state_n = S_DATA;
            end
            S_DATA: begin
                if (cyc_last) begin
                    shreg_n = shreg >> 1;
                    if (bitc == BIT_LAST) begin
                        state_n = S_PARITY;
                        bitc_n  = '0;
                    end else begin
                        bitc_n  = bitc + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (cyc_last) state_n = S_STOP;
            end
            S_STOP: begin
                if (cyc_last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // tx is registered from next-state values so it lines up with the state it belongs to
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= accept && ((^in_data) != in_parity);
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Serial framing transmitter that consumes a 32-bit word and its even-parity bit from the parity generator stage. It shifts out one frame on a single line: a start bit, the data bits LSB first, the parity bit, then a stop bit. It uses a valid/ready handshake on the input side. It sits directly downstream of the parity generator and drives the off-block serial link.

Parameters:
DATA_W, 32, data word width in bits (parity generator output width)
BIT_CYCLES, 4, clock cycles per serial bit; legal range 1..255

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  word to transmit
in_parity  input  1  even-parity bit for in_data (XOR of all in_data bits)
in_valid  input  1  in_data/in_parity valid
in_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame
par_err  output  1  parity mismatch pulse (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, tx=1, busy=0, done=0, par_err=0, in_ready=1, bit counter=0, cycle counter=0. The effect is immediate, without waiting for a clock edge.
- Reset mid-frame: the frame is abandoned, tx returns high at once, and nothing is resumed after reset deasserts.
- Handshake: in_ready=1 only in IDLE.
  - Accept occurs on a rising edge with in_valid & in_ready.
  - On accept, the block latches in_data into the shift register and in_parity into the parity register, then goes to START.
  - in_valid while not ready is ignored. Inputs need not stay stable after accept.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - START drives tx=0 for BIT_CYCLES clocks.
  - DATA drives tx=shift_reg[0] for BIT_CYCLES clocks per bit, then shifts right by 1. It stays in DATA until DATA_W bits have been sent; the bit counter runs 0..DATA_W-1.
  - PARITY drives tx=latched parity for BIT_CYCLES clocks.
  - STOP drives tx=1 for BIT_CYCLES clocks.
  - On the last cycle of STOP, done=1 for that single cycle and the state moves to IDLE.
- Timing:
  - tx first goes low the cycle after accept.
  - The frame lasts exactly (DATA_W+3)*BIT_CYCLES cycles; 140 with the defaults.
  - in_ready reasserts the cycle after done.
  - The back-to-back throughput minimum is one IDLE cycle between frames.
- busy=1 in every state except IDLE.
- Cycle counter: counts 0..BIT_CYCLES-1 and wraps to 0 on each bit boundary. With BIT_CYCLES=1 every state advances each clock.
- tx is registered, so there are no combinational paths from inputs to tx.
- The block performs no parity computation in the default build; in_parity is transmitted verbatim.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined: on accept, the block computes the XOR-reduction of in_data and compares it with in_parity.
  - On mismatch, par_err=1 for exactly one cycle, the cycle after accept (coincident with the first START cycle).
  - The frame is still sent using the supplied in_parity, so a fault is not masked.
- Not defined: par_err is tied to 0 and no checker logic exists.
- Frame timing is identical in both builds.

Test Plan:
- Reset check: hold rst_n=0 and toggle inputs -> tx=1, in_ready=1, busy=0, done=0, par_err=0; asserting rst_n=0 asynchronously between clock edges forces these values immediately.
- Single frame: BIT_CYCLES=4, in_data=32'h00000001, in_parity=1 -> start bit 0 for 4 cycles; data bit0=1 then 31 zeros, each held 4 cycles; parity 1 for 4 cycles; stop 1 for 4 cycles; done pulses at cycle 140 after accept; in_ready=1 the next cycle.
- Pattern frame: in_data=32'hABC1FF06, in_parity=0 -> sampled data bits mid-bit reproduce 32'hABC1FF06 LSB first and the parity slot is 0.
- Handshake: in_valid held high with a new word during a frame -> not accepted until in_ready=1. A second frame then starts exactly 1 IDLE cycle after done, with no data corruption of frame 1.
- Reset mid-frame: assert rst_n=0 during DATA bit 10 -> tx=1 immediately and busy=0. After release, in_ready=1 and a new frame transmits correctly from the start bit.
- PARITY_CHECK_EN build: in_data=32'h00000003, in_parity=1 -> par_err=1 for one cycle after accept and the parity slot still carries 1. With in_parity=0, par_err stays 0.
